// File: rtl/glitch_sequencer.sv
// Fault-injection glitch sequencer: optional target reset, delay, then a train of glitch pulses.
// Optional external trigger wait is enabled by defining GLITCH_EXT_TRIGGER_EN.
module glitch_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_en_i,
  input  logic        reset_en_i,
  input  logic        abort_i,
  input  logic        trigger_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  output logic        glitch_o,
  output logic        target_rst_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_DELAY     = 3'd3,
    S_PULSE     = 3'd4,
    S_SPACE     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [7:0]  r_pulses;
  logic [7:0]  w_pulses_next;
  logic [15:0] r_delay;
  logic [7:0]  r_width;
  logic [7:0]  r_num;
  logic [15:0] r_space;

  logic        w_idle;
  logic        w_start;
  logic        w_trig_rise;
  logic [15:0] w_delay_sel;
  logic [7:0]  w_width_sel;
  logic [7:0]  w_num_sel;
  state_t      w_glitch_state;
  state_t      w_dly_state;
  logic [15:0] w_dly_cnt;
  logic        w_go_arm;
  logic        w_go_dly;
  logic        w_go_glitch;

  assign w_idle  = (r_state == S_IDLE);
  assign w_start = pulse_en_i | reset_en_i;
  assign busy_o  = !w_idle;

  // In IDLE the snapshots are not loaded yet, so decisions use the live inputs.
  assign w_delay_sel = w_idle ? delay_i      : r_delay;
  assign w_width_sel = w_idle ? width_i      : r_width;
  assign w_num_sel   = w_idle ? num_pulses_i : r_num;

  assign w_glitch_state = (w_num_sel == 8'd0 || w_width_sel == 8'd0) ? S_DONE : S_PULSE;
  assign w_dly_state    = (w_delay_sel != 16'd0) ? S_DELAY : w_glitch_state;
  assign w_dly_cnt      = (w_delay_sel != 16'd0) ? w_delay_sel : {8'd0, w_width_sel};

`ifdef GLITCH_EXT_TRIGGER_EN
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_trig_prev;
  logic                   r_trig_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_trig_prev <= 1'b0;
      r_trig_rise <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], trigger_i};
      r_trig_prev <= r_sync[SYNC_STAGES-1];
      r_trig_rise <= r_sync[SYNC_STAGES-1] & ~r_trig_prev;
    end
  end

  assign w_trig_rise = r_trig_rise;
`else
  assign w_trig_rise = trigger_i & (SYNC_STAGES == 0);
`endif

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pulses_next = r_pulses;
    w_go_arm      = 1'b0;
    w_go_dly      = 1'b0;
    w_go_glitch   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (reset_en_i && reset_length_i != 16'd0) begin
          w_state_next = S_RESET;
          w_cnt_next   = reset_length_i;
        end else if (w_start) begin
          w_go_arm = 1'b1;
        end
      end
      S_RESET: begin
        if (r_cnt == 16'd1) w_go_arm = 1'b1;
        else                w_cnt_next = r_cnt - 16'd1;
      end
      S_WAIT_TRIG: begin
        if (w_trig_rise) w_go_dly = 1'b1;
      end
      S_DELAY: begin
        if (r_cnt == 16'd1) w_go_glitch = 1'b1;
        else                w_cnt_next = r_cnt - 16'd1;
      end
      S_PULSE: begin
        if (r_cnt == 16'd1) begin
          if (r_pulses == 8'd1) begin
            w_state_next = S_DONE;
          end else begin
            // Zero spacing chains the next pulse directly, keeping glitch_o high.
            w_pulses_next = r_pulses - 8'd1;
            w_state_next  = (r_space != 16'd0) ? S_SPACE : S_PULSE;
            w_cnt_next    = (r_space != 16'd0) ? r_space : {8'd0, r_width};
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_SPACE: begin
        if (r_cnt == 16'd1) begin
          w_state_next = S_PULSE;
          w_cnt_next   = {8'd0, r_width};
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

`ifdef GLITCH_EXT_TRIGGER_EN
    if (w_go_arm) w_state_next = S_WAIT_TRIG;
`else
    if (w_go_arm) w_go_dly = 1'b1;
`endif
    if (w_go_dly) begin
      w_state_next  = w_dly_state;
      w_cnt_next    = w_dly_cnt;
      w_pulses_next = w_num_sel;
    end
    if (w_go_glitch) begin
      w_state_next = w_glitch_state;
      w_cnt_next   = {8'd0, w_width_sel};
    end
    if (abort_i && !w_idle) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pulses     <= '0;
      r_delay      <= '0;
      r_width      <= '0;
      r_num        <= '0;
      r_space      <= '0;
      glitch_o     <= 1'b0;
      target_rst_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_pulses <= w_pulses_next;
      if (w_idle && w_start) begin
        r_delay <= delay_i;
        r_width <= width_i;
        r_num   <= num_pulses_i;
        r_space <= pulse_spacing_i;
      end
      glitch_o     <= (w_state_next == S_PULSE);
      target_rst_o <= (w_state_next == S_RESET);
      done_o       <= (w_state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: per-cycle output masks compared with hand-derived patterns.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_en_i = 1'b0;
  logic        reset_en_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        trigger_i = 1'b0;
  logic [15:0] delay_i = '0;
  logic [7:0]  width_i = '0;
  logic [7:0]  num_pulses_i = '0;
  logic [15:0] pulse_spacing_i = '0;
  logic [15:0] reset_length_i = '0;
  logic        glitch_o;
  logic        target_rst_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_glitch, m_trst, m_done, m_busy;
  int done_seen;

  glitch_sequencer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .pulse_en_i(pulse_en_i), .reset_en_i(reset_en_i), .abort_i(abort_i), .trigger_i(trigger_i),
    .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i), .reset_length_i(reset_length_i),
    .glitch_o(glitch_o), .target_rst_o(target_rst_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cfg(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                     input logic [15:0] sp, input logic [15:0] rl);
    delay_i = d; width_i = w; num_pulses_i = n; pulse_spacing_i = sp; reset_length_i = rl;
  endtask

  // Strobe in cycle 0, then record outputs of cycles 0..ncyc-1 as bit masks.
  task automatic run(input logic rs, input logic ps, input int ncyc,
                     input int abort_at, input int trig_at, input int noise_at);
    m_glitch = '0; m_trst = '0; m_done = '0; m_busy = '0;
    @(posedge clk); #1;
    reset_en_i = rs; pulse_en_i = ps;
    if (trig_at == 0) trigger_i = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      m_glitch[k] = glitch_o; m_trst[k] = target_rst_o;
      m_done[k] = done_o;     m_busy[k] = busy_o;
      @(posedge clk); #1;
      reset_en_i = 1'b0; pulse_en_i = 1'b0; abort_i = 1'b0;
      if (k + 1 == abort_at) abort_i = 1'b1;
      if (trig_at >= 0 && k + 1 >= trig_at) trigger_i = 1'b1;
      if (k + 1 == noise_at) begin
        pulse_en_i = 1'b1; reset_en_i = 1'b1;
        cfg(16'd0, 8'd9, 8'd7, 16'd0, 16'd3);
      end
    end
    reset_en_i = 1'b0; pulse_en_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_glitch", {31'd0, glitch_o}, 32'd0);
    check("rst_trst",   {31'd0, target_rst_o}, 32'd0);
    check("rst_busy",   {31'd0, busy_o}, 32'd0);
    check("rst_done",   {31'd0, done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef GLITCH_EXT_TRIGGER_EN
    // Trigger rises in cycle 10; config/start noise in cycle 5 must be ignored.
    cfg(16'd2, 8'd1, 8'd1, 16'd0, 16'd0);
    run(1'b0, 1'b1, 24, -1, 10, 5);
    check("trig_glitch", m_glitch, 32'h0001_0000);
    check("trig_done",   m_done,   32'h0002_0000);
    check("trig_busy",   m_busy,   32'h0003_FFFE);
    // A level already high before the run must not count as a trigger.
    trigger_i = 1'b1;
    repeat (6) @(negedge clk);
    cfg(16'd1, 8'd1, 8'd1, 16'd0, 16'd0);
    run(1'b0, 1'b1, 24, 20, 0, -1);
    check("stale_glitch", m_glitch, 32'h0);
    check("stale_done",   m_done,   32'h0);
    check("stale_busy",   m_busy,   32'h001F_FFFE);
`else
    cfg(16'd3, 8'd2, 8'd1, 16'd0, 16'd0);
    run(1'b0, 1'b1, 10, -1, -1, -1);
    check("basic_glitch", m_glitch, 32'h30);
    check("basic_done",   m_done,   32'h40);
    check("basic_busy",   m_busy,   32'h7E);
    check("basic_trst",   m_trst,   32'h0);

    cfg(16'd0, 8'd1, 8'd3, 16'd2, 16'd5);
    run(1'b1, 1'b0, 16, -1, -1, -1);
    check("rseq_trst",   m_trst,   32'h3E);
    check("rseq_glitch", m_glitch, 32'h1240);
    check("rseq_done",   m_done,   32'h2000);
    check("rseq_busy",   m_busy,   32'h3FFE);

    cfg(16'd4, 8'd5, 8'd0, 16'd0, 16'd0);
    run(1'b0, 1'b1, 8, -1, -1, -1);
    check("num0_glitch", m_glitch, 32'h0);
    check("num0_done",   m_done,   32'h20);
    check("num0_busy",   m_busy,   32'h3E);

    cfg(16'd1, 8'd3, 8'd4, 16'd2, 16'd0);
    run(1'b0, 1'b1, 20, 8, -1, -1);
    check("abort_glitch", m_glitch, 32'h19C);
    check("abort_busy",   m_busy,   32'h1FE);
    check("abort_done",   m_done,   32'h0);

    cfg(16'd0, 8'd2, 8'd3, 16'd0, 16'd0);
    run(1'b0, 1'b1, 10, -1, -1, -1);
    check("merge_glitch", m_glitch, 32'h7E);
    check("merge_done",   m_done,   32'h80);
    check("merge_busy",   m_busy,   32'hFE);

    cfg(16'd1, 8'd1, 8'd1, 16'd0, 16'd2);
    run(1'b1, 1'b1, 8, -1, -1, -1);
    check("prio_trst",   m_trst,   32'h6);
    check("prio_glitch", m_glitch, 32'h10);
    check("prio_done",   m_done,   32'h20);

    cfg(16'd0, 8'd1, 8'd1, 16'd0, 16'd0);
    run(1'b1, 1'b0, 6, -1, -1, -1);
    check("rl0_trst",   m_trst,   32'h0);
    check("rl0_glitch", m_glitch, 32'h2);
    check("rl0_done",   m_done,   32'h4);

    cfg(16'd2, 8'd2, 8'd1, 16'd0, 16'd0);
    run(1'b0, 1'b1, 10, -1, -1, 3);
    check("snap_glitch", m_glitch, 32'h18);
    check("snap_done",   m_done,   32'h20);
    check("snap_busy",   m_busy,   32'h3E);

    cfg(16'd2, 8'd0, 8'd2, 16'd0, 16'd0);
    run(1'b0, 1'b1, 6, -1, -1, -1);
    check("w0_glitch", m_glitch, 32'h0);
    check("w0_done",   m_done,   32'h8);
`endif

    // Asynchronous reset in the middle of target reset and of a pulse.
    cfg(16'd0, 8'd10, 8'd1, 16'd0, 16'd10);
    @(posedge clk); #1 reset_en_i = 1'b1;
    @(posedge clk); #1 reset_en_i = 1'b0;
    @(negedge clk);
    check("midrst_trst_before", {31'd0, target_rst_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_trst_after", {31'd0, target_rst_o}, 32'd0);
    check("midrst_busy_after", {31'd0, busy_o}, 32'd0);
    @(negedge clk) rst = 1'b0;

`ifndef GLITCH_EXT_TRIGGER_EN
    @(posedge clk); #1 pulse_en_i = 1'b1;
    @(posedge clk); #1 pulse_en_i = 1'b0;
    @(negedge clk);
    check("midrst_glitch_before", {31'd0, glitch_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_glitch_after", {31'd0, glitch_o}, 32'd0);
    @(negedge clk) rst = 1'b0;
`endif
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    check("midrst_no_done", done_seen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the trigger_i synchronizer depth (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pulse_en_i  input  1  one-cycle start strobe, glitch run without target reset.
REQ-005 SHALL have port reset_en_i  input  1  one-cycle start strobe, target reset then glitch run.
REQ-006 SHALL have port abort_i  input  1  cancel run in progress.
REQ-007 SHALL have port trigger_i  input  1  asynchronous target trigger, used only per REQ-030.
REQ-008 SHALL have port delay_i  input  16  cycles from start (or trigger) to first glitch.
REQ-009 SHALL have port width_i  input  8  glitch pulse width in cycles.
REQ-010 SHALL have port num_pulses_i  input  8  number of glitch pulses.
REQ-011 SHALL have port pulse_spacing_i  input  16  low cycles between consecutive pulses.
REQ-012 SHALL have port reset_length_i  input  16  target reset assertion length in cycles.
REQ-013 SHALL have port glitch_o  output  1  registered glitch drive.
REQ-014 SHALL have port target_rst_o  output  1  registered target reset drive, active-high.
REQ-015 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done_o  output  1  one-cycle strobe on normal run completion.

Function
REQ-017 SHALL implement states IDLE, RESET, WAIT_TRIG, DELAY, PULSE, SPACE, DONE.
REQ-018 SHALL accept a start only in IDLE; strobes in other states are ignored, with no queuing.
REQ-019 SHALL give reset_en_i priority when pulse_en_i and reset_en_i are high in the same cycle.
REQ-020 SHALL snapshot delay, width, num_pulses, spacing and reset_length on the accepting edge; later input changes do not affect the run.
REQ-021 SHALL, on reset_en_i with reset_length nonzero, enter RESET and hold target_rst_o high for exactly reset_length cycles; with reset_length 0, RESET is skipped.
REQ-022 SHALL leave RESET (or IDLE for pulse_en_i) into WAIT_TRIG or DELAY per REQ-030.
REQ-023 SHALL keep glitch_o low for exactly delay cycles after entering DELAY; delay 0 gives zero cycles.
REQ-024 SHALL drive glitch_o high for exactly width cycles per pulse in PULSE.
REQ-025 SHALL drive glitch_o low for exactly spacing cycles in SPACE between pulses; there is no SPACE after the last pulse; spacing 0 merges pulses into one continuous high of num_pulses*width cycles.
REQ-026 SHALL, with num_pulses 0 or width 0, never assert glitch_o and go from DELAY straight to DONE.
REQ-027 SHALL spend exactly one cycle in DONE, with done_o=1 and busy_o=1, then return to IDLE.
REQ-028 SHALL, on abort_i in any non-IDLE state, go to IDLE on the next edge, with glitch_o and target_rst_o low from that edge and no done_o; abort_i has priority over counter expiry.
REQ-029 SHALL use 16-bit down-counters with no wrap: maximum values 65535/255 run to full length.

Configuration
REQ-030 SHALL honour macro GLITCH_EXT_TRIGGER_EN: when defined, trigger_i passes a SYNC_STAGES flop synchronizer and rising-edge detector, WAIT_TRIG holds until a detected rising edge, then enters DELAY on the next edge; when undefined, WAIT_TRIG and the synchronizer are absent, trigger_i is ignored, and DELAY is entered directly.
REQ-031 SHALL, with GLITCH_EXT_TRIGGER_EN defined, ignore a trigger level already high on WAIT_TRIG entry; only a new rising edge counts.

Reset
REQ-032 SHALL, while rst is high, asynchronously force state IDLE, glitch_o=0, target_rst_o=0, busy_o=0, done_o=0, all counters, snapshots and synchronizer flops to 0.
REQ-033 SHALL, on rst mid-run, drop glitch_o and target_rst_o immediately; no done_o follows.

Verification
REQ-034 SHALL pass: pulse_en_i at cycle 0, delay=3, width=2, num=1 (macro off) -> glitch_o high cycles 4-5, done_o cycle 6, busy_o low cycle 7.
REQ-035 SHALL pass: reset_en_i, reset_length=5, delay=0, width=1, num=3, spacing=2 -> target_rst_o high 5 cycles, then glitch pattern 1 high, 2 low, 1 high, 2 low, 1 high, then done_o.
REQ-036 SHALL pass: num=0, delay=4 -> glitch_o never high, done_o exactly 5 cycles after start.
REQ-037 SHALL pass: abort_i during the second pulse of num=4 -> glitch_o low next cycle, busy_o low, no done_o.
REQ-038 SHALL pass: macro on, trigger_i rises 10 cycles after start, delay=2 -> glitch_o rises SYNC_STAGES+4 cycles after the trigger_i rise, with starts and config changes during the run ignored.
